// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed from a power-of-two byte FIFO, driving the RsTx line.
// Frames go out back-to-back, with no idle gap, for as long as the FIFO holds data.
module uart_tx_fifo #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          busy,
   output logic                          RsTx
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          push;
   logic          pop;
   logic          bit_end;

   assign in_ready = reset & (level != FULL_LEVEL);
   assign push     = in_valid & in_ready;
   assign bit_end  = (cnt == CNT_LAST);

   // A pop happens when a new frame starts: from IDLE, or at the end of a stop bit.
   always_comb begin
      pop = 1'b0;
      if (reset && (level != '0)) begin
         if (state == IDLE) begin
            pop = 1'b1;
         end else if ((state == STOP) && bit_end) begin
            pop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            level <= level + LEVEL_ONE;
         end else if (pop && !push) begin
            level <= level - LEVEL_ONE;
         end
      end
   end

   // Every bit, start and stop included, lasts exactly DIV clocks of cnt.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         RsTx    <= 1'b1;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               RsTx <= 1'b1;
               cnt  <= '0;
               if (pop) begin
                  shift <= mem[rd_ptr];
                  RsTx  <= 1'b0;
                  state <= START;
                  busy  <= 1'b1;
               end
            end

            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  RsTx    <= shift[0];
                  bit_idx <= '0;
                  state   <= DATA;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     RsTx  <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift   <= {1'b0, shift[7:1]};
                     RsTx    <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (pop) begin
                     shift <= mem[rd_ptr];
                     RsTx  <= 1'b0;
                     state <= START;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               RsTx  <= 1'b1;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: constant vectors for reset and the first frame, directed corner
// sequences, then random traffic against a frame-level queue model and a line receiver.
module tb_uart_tx_fifo;

   localparam int CLK_HZ = 1000;
   localparam int BAUD   = 100;
   localparam int DIV    = CLK_HZ / BAUD;
   localparam int DEPTH  = 16;
   localparam int FRAME  = 10 * DIV;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [4:0] level;
   logic       busy;
   logic       RsTx;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .CLK_HZ(CLK_HZ),
      .BAUD(BAUD),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .level(level),
      .busy(busy),
      .RsTx(RsTx)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Reference model: queued bytes plus the byte on the line and its position in the frame.
   logic [7:0] mq[$];
   bit         m_active = 1'b0;
   int         m_pos    = 0;
   logic [7:0] m_cur    = 8'h00;
   bit         last_accept;

   logic [7:0] rx_q[$];
   bit         rx_active = 1'b0;
   int         rx_t      = 0;
   logic [7:0] rx_byte   = 8'h00;
   logic       prev_tx   = 1'b1;
   int         falls[$];

   typedef struct {
      logic       rst;
      logic       v;
      logic [7:0] d;
      logic       tx;
      logic       bsy;
      int         lvl;
      logic       rdy;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: actual %0h, required %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic model_tx();
      if (!m_active) return 1'b1;
      if (m_pos < DIV) return 1'b0;
      if (m_pos < 9 * DIV) return m_cur[(m_pos - DIV) / DIV];
      return 1'b1;
   endfunction

   task automatic check_output();
      check("tx", RsTx, model_tx());
      check("busy", busy, m_active);
      check("level", level, mq.size());
      check("in_ready", in_ready, reset && (mq.size() != DEPTH));
   endtask

   // Drive one clock of inputs, advance the model past the edge, then compare on the falling edge.
   task automatic apply_stimulus(input logic r, input logic v, input logic [7:0] d);
      reset       = r;
      in_valid    = v;
      in_data     = d;
      last_accept = r && v && (mq.size() != DEPTH);
      @(posedge clk);
      cyc++;
      if (!r) begin
         mq.delete();
         m_active = 1'b0;
         m_pos    = 0;
      end else begin
         if (m_active) begin
            if (m_pos == FRAME - 1) begin
               if (mq.size() != 0) begin
                  m_cur = mq.pop_front();
                  m_pos = 0;
               end else begin
                  m_active = 1'b0;
               end
            end else begin
               m_pos++;
            end
         end else if (mq.size() != 0) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
         end
         if (last_accept) mq.push_back(d);
      end
      @(negedge clk);
      check_output();
      if (!r) begin
         rx_active = 1'b0;
      end else if (rx_active) begin
         rx_t++;
         if (rx_t >= 15 && rx_t <= 85 && (rx_t % 10) == 5) rx_byte[(rx_t - 15) / 10] = RsTx;
         if (rx_t == 95) begin
            check("stop_bit", RsTx, 1'b1);
            rx_q.push_back(rx_byte);
            rx_active = 1'b0;
         end
      end else if (prev_tx === 1'b1 && RsTx === 1'b0) begin
         rx_active = 1'b1;
         rx_t      = 0;
         falls.push_back(cyc);
      end
      prev_tx = RsTx;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((m_active || mq.size() != 0) && n < budget) begin
         apply_stimulus(1'b1, 1'b0, 8'h00);
         n++;
      end
      if (m_active || mq.size() != 0) check("idle_timeout", 0, 1);
      for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b0, 8'h00);
   endtask

   initial begin
      logic [9:0] pat;
      int         push_cyc;
      int         acc;
      int         first;
      int         t17;

      tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 0, 1'b1};
      tbl[4] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1, 1'b1};
      tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1};

      push_cyc = 0;
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(tbl[i].rst, tbl[i].v, tbl[i].d);
         check("tbl_tx", RsTx, tbl[i].tx);
         check("tbl_busy", busy, tbl[i].bsy);
         check("tbl_level", level, tbl[i].lvl);
         check("tbl_ready", in_ready, tbl[i].rdy);
         if (i == 4) push_cyc = cyc;
      end

      // Rest of the 0xA5 frame: bit k/10 of {stop, data LSB first, start}.
      pat = {1'b1, 8'hA5, 1'b0};
      for (int k = 1; k < FRAME; k++) begin
         apply_stimulus(1'b1, 1'b0, 8'h00);
         check("a5_tx", RsTx, pat[k / DIV]);
         check("a5_busy", busy, 1'b1);
      end
      apply_stimulus(1'b1, 1'b0, 8'h00);
      check("a5_busy_end", busy, 1'b0);
      check("a5_tx_end", RsTx, 1'b1);
      check("a5_rx_count", rx_q.size(), 1);
      if (rx_q.size() >= 1) check("a5_rx_byte", rx_q[0], 8'hA5);
      check("a5_fall_count", falls.size(), 1);
      if (falls.size() >= 1) check("a5_latency", falls[0], push_cyc + 1);

      // Two bytes on consecutive edges: start bits exactly one frame apart.
      rx_q.delete();
      falls.delete();
      apply_stimulus(1'b1, 1'b1, 8'h00);
      apply_stimulus(1'b1, 1'b1, 8'hFF);
      wait_idle(4 * FRAME);
      check("b2b_falls", falls.size(), 2);
      if (falls.size() >= 2) check("b2b_spacing", falls[1] - falls[0], FRAME);
      check("b2b_rx_count", rx_q.size(), 2);
      if (rx_q.size() >= 2) begin
         check("b2b_rx0", rx_q[0], 8'h00);
         check("b2b_rx1", rx_q[1], 8'hFF);
      end

      // Fill past full with in_valid held; the 18th byte waits for the first pop.
      rx_q.delete();
      falls.delete();
      acc   = 0;
      first = 0;
      t17   = 0;
      for (int k = 0; k < 400 && acc < 18; k++) begin
         apply_stimulus(1'b1, 1'b1, 8'(acc));
         if (last_accept) begin
            if (acc == 0) first = cyc;
            if (acc == 16) begin
               check("full_level", level, 16);
               check("full_ready", in_ready, 1'b0);
            end
            if (acc == 17) t17 = cyc;
            acc++;
         end
      end
      check("full_accepted", acc, 18);
      check("full_resume", t17 - first, FRAME + 2);
      wait_idle(20 * FRAME);
      check("full_rx_count", rx_q.size(), 18);
      for (int k = 0; k < 18 && k < rx_q.size(); k++) check("full_order", rx_q[k], 8'(k));

      // Reset 45 clocks into a frame with three bytes queued behind it.
      rx_q.delete();
      falls.delete();
      apply_stimulus(1'b1, 1'b1, 8'h11);
      apply_stimulus(1'b1, 1'b1, 8'h22);
      apply_stimulus(1'b1, 1'b1, 8'h33);
      apply_stimulus(1'b1, 1'b1, 8'h44);
      check("abort_level", level, 3);
      for (int k = 0; k < FRAME && m_active && m_pos < 44; k++) apply_stimulus(1'b1, 1'b0, 8'h00);
      apply_stimulus(1'b0, 1'b0, 8'h00);
      check("abort_tx", RsTx, 1'b1);
      check("abort_level0", level, 0);
      check("abort_busy", busy, 1'b0);
      for (int k = 0; k < 3 * FRAME; k++) apply_stimulus(1'b1, 1'b0, 8'h00);
      check("abort_no_frames", falls.size(), 1);
      check("abort_no_bytes", rx_q.size(), 0);

      // Push on the same edge that the stop bit ends and pops: level holds at 5.
      rx_q.delete();
      falls.delete();
      for (int k = 0; k < 6; k++) apply_stimulus(1'b1, 1'b1, 8'(8'h61 + k));
      check("pp_level_before", level, 5);
      for (int k = 0; k < 2 * FRAME && !(m_active && m_pos == FRAME - 1); k++)
         apply_stimulus(1'b1, 1'b0, 8'h00);
      apply_stimulus(1'b1, 1'b1, 8'h3C);
      check("pp_level_after", level, 5);
      wait_idle(10 * FRAME);
      check("pp_rx_count", rx_q.size(), 7);
      if (rx_q.size() >= 7) begin
         for (int k = 0; k < 6; k++) check("pp_order", rx_q[k], 8'(8'h61 + k));
         check("pp_last", rx_q[6], 8'h3C);
      end

      // Random traffic with occasional resets, judged by the model every clock.
      for (int k = 0; k < 3000; k++) begin
         logic r;
         logic v;
         r = ($urandom_range(0, 299) != 0);
         v = (k % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 29) == 0);
         apply_stimulus(r, v, 8'($urandom));
      end
      wait_idle(20 * FRAME);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
